spi_light_slave: RTL
====================

// Module: spi_light_slave
// PURPOSE
//  SPI receive stage downstream of spi_master in the traffic_light design. Runs on the same
//  clk as the master (spi_sclk == clk), samples spi_mosi while spi_ss_n is low, decodes the
//  7-bit frame {start=1, cmd, addr[1:0], data[2:0]}, and writes one of four 3-bit light
//  registers that directly drive the lamp outputs. Short or malformed frames are flagged.
// PARAMETERS
//  RST_VAL   3'b100  reset/init value of every light register ({R,Y,G} = red on)
//  MAX_HUNT  4       max cycles with ss_n low and no start bit before frame_err (range 1..15)
// PORTS
//  clk         in   1   system clock; all logic on posedge; only clock in the block
//  n_rst       in   1   asynchronous active-low reset
//  spi_ss_n    in   1   slave select, active low, synchronous to clk
//  spi_mosi    in   1   serial data, MSB (start bit) first, sampled on posedge clk
//  spi_miso    out  1   readback data (see CONFIGURATION); 0 when unused
//  light_out   out  12  {reg3,reg2,reg1,reg0}, each 3-bit {R,Y,G}
//  frame_ok    out  1   one-cycle pulse: valid frame committed
//  frame_err   out  1   one-cycle pulse: frame aborted (short frame or hunt timeout)
// BEHAVIOUR
//  Reset: state=S_IDLE, all regs=RST_VAL, light_out={4{RST_VAL}}, spi_miso/frame_ok/frame_err=0.
//  FSM (registered state, 3 bits):
//   S_IDLE   : ss_n==0 -> S_HUNT (hunt counter cleared).
//   S_HUNT   : ss_n==1 -> S_IDLE, no pulse. mosi==1 -> S_SHIFT, bit counter=0.
//              MAX_HUNT samples of mosi==0 with ss_n low -> S_WAIT + frame_err pulse.
//   S_SHIFT  : shift mosi into 6-bit sreg (MSB first); bit counter 0..5. 6th bit -> S_COMMIT.
//              ss_n==1 before 6th bit sampled -> S_IDLE + frame_err pulse; no register write.
//   S_COMMIT : single cycle; ignores ss_n (the master raises ss_n the edge after d0).
//              cmd=1: reg[addr] <= data; cmd=0: read (CONFIGURATION). frame_ok pulses next
//              cycle. -> S_WAIT if ss_n==0 at this edge, else S_IDLE.
//   S_WAIT   : ignore mosi until ss_n==1 -> S_IDLE. Extra bits after a frame are discarded.
//  Latency: d0 sampled at edge N; light_out and frame_ok change at edge N+1.
//  With spi_master: start bit sampled 3 edges after ss_n falls; commit coincides with ss_n rise.
//  Back-to-back frames: ss_n high for >=1 sampled cycle between frames; every frame decoded.
//  frame_ok and frame_err are never high together; each is exactly one cycle wide.
//  Writes to one address never disturb the other three registers.
//  Reset mid-frame: immediate return to reset state; partial frame discarded, no pulse.
// CONFIGURATION
//  SPI_LIGHT_READBACK_EN defined: cmd=0 loads reg[addr] into a 3-bit tx shifter in S_COMMIT;
//   spi_miso drives bits 2,1,0 on the 3 cycles after commit while ss_n==0; 0 otherwise.
//   ss_n rising mid-readback zeroes spi_miso at the next edge. frame_ok still pulses.
//  Not defined: cmd=0 frames are decoded, no write, frame_ok pulses; spi_miso tied 0.
// TESTING
//  1 Reset: n_rst low -> light_out=12'h924, spi_miso=0, no pulses.
//  2 spi_master sends cmd=1 addr=2 data=3'b001 -> light_out[8:6]=001 one edge after d0,
//    frame_ok one cycle, other fields stay 100.
//  3 ss_n raised after 3 shifted bits -> frame_err one cycle, light_out unchanged.
//  4 ss_n low, mosi held 0 for MAX_HUNT cycles -> frame_err; a later 1 on mosi is ignored
//    until ss_n rises.
//  5 Two frames back-to-back (addr0=010, addr3=001) -> light_out=12'h322 after second,
//    two frame_ok pulses.
//  6 READBACK_EN: write addr1=011, then cmd=0 addr=1 with ss_n held 4 extra cycles ->
//    spi_miso 0,1,1; without the macro spi_miso stays 0.

Source files
------------

// File: rtl/spi_light_if.sv
// SPI link and lamp-status bundle between spi_master (or a bench) and spi_light_slave.
interface spi_light_if;
  logic        spi_ss_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic [11:0] light_out;
  logic        frame_ok;
  logic        frame_err;

  modport master (
    output spi_ss_n, spi_mosi,
    input  spi_miso, light_out, frame_ok, frame_err
  );

  modport slave (
    input  spi_ss_n, spi_mosi,
    output spi_miso, light_out, frame_ok, frame_err
  );
endinterface

// File: rtl/spi_light_slave.sv
// SPI receive stage for the traffic light: decodes {start,cmd,addr[1:0],data[2:0]} frames into
// four 3-bit {R,Y,G} light registers. Optional readback on spi_miso with `SPI_LIGHT_READBACK_EN.
module spi_light_slave #(
  parameter logic [2:0]  RST_VAL  = 3'b100,
  parameter int unsigned MAX_HUNT = 4
) (
  input  logic        clk,
  input  logic        n_rst,
  spi_light_if.slave  spi
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HUNT   = 3'd1,
    S_SHIFT  = 3'd2,
    S_COMMIT = 3'd3,
    S_WAIT   = 3'd4
  } state_t;

  localparam logic [3:0] HUNT_LAST = 4'(MAX_HUNT - 1);

  state_t      state_r;
  state_t      state_nxt_s;
  logic        err_set_s;
  logic [3:0]  hunt_cnt_r;
  logic [2:0]  bit_cnt_r;
  logic [5:0]  sreg_r;
  logic [2:0]  light_r [4];
  logic        frame_ok_r;
  logic        frame_err_r;

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and abort detection
  always_comb begin
    state_nxt_s = state_r;
    err_set_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!spi.spi_ss_n) state_nxt_s = S_HUNT;
        else               state_nxt_s = S_IDLE;
      end
      S_HUNT: begin
        if (spi.spi_ss_n) begin
          state_nxt_s = S_IDLE;
        end else if (spi.spi_mosi) begin
          state_nxt_s = S_SHIFT;
        end else if (hunt_cnt_r == HUNT_LAST) begin
          state_nxt_s = S_WAIT;
          err_set_s   = 1'b1;
        end else begin
          state_nxt_s = S_HUNT;
        end
      end
      S_SHIFT: begin
        if (spi.spi_ss_n) begin
          state_nxt_s = S_IDLE;
          err_set_s   = 1'b1;
        end else if (bit_cnt_r == 3'd5) begin
          state_nxt_s = S_COMMIT;
        end else begin
          state_nxt_s = S_SHIFT;
        end
      end
      // The master releases ss_n on this very edge, so ss_n only selects where to go next.
      S_COMMIT: begin
        if (!spi.spi_ss_n) state_nxt_s = S_WAIT;
        else               state_nxt_s = S_IDLE;
      end
      S_WAIT: begin
        if (spi.spi_ss_n) state_nxt_s = S_IDLE;
        else              state_nxt_s = S_WAIT;
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Hunt/bit counters, frame shifter and status pulses
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hunt_cnt_r  <= 4'd0;
      bit_cnt_r   <= 3'd0;
      sreg_r      <= 6'd0;
      frame_ok_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      frame_ok_r  <= (state_r == S_COMMIT);
      frame_err_r <= err_set_s;
      if (state_r == S_HUNT) hunt_cnt_r <= hunt_cnt_r + 4'd1;
      else                   hunt_cnt_r <= 4'd0;
      if (state_r == S_SHIFT) begin
        sreg_r    <= {sreg_r[4:0], spi.spi_mosi};
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end else begin
        sreg_r    <= sreg_r;
        bit_cnt_r <= 3'd0;
      end
    end
  end

  // Light registers: only the addressed register changes on a write commit
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 4; i++) light_r[i] <= RST_VAL;
    end else if ((state_r == S_COMMIT) && sreg_r[5]) begin
      light_r[sreg_r[4:3]] <= sreg_r[2:0];
    end else begin
      for (int i = 0; i < 4; i++) light_r[i] <= light_r[i];
    end
  end

  assign spi.light_out = {light_r[3], light_r[2], light_r[1], light_r[0]};
  assign spi.frame_ok  = frame_ok_r;
  assign spi.frame_err = frame_err_r;

`ifdef SPI_LIGHT_READBACK_EN
  logic [2:0] rd_s;
  logic [2:0] tx_sh_r;
  logic [1:0] tx_cnt_r;
  logic       miso_r;

  assign rd_s = light_r[sreg_r[4:3]];

  // Readback shifter: bit 2 leaves on the commit edge, bits 1 and 0 follow while ss_n stays low
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tx_sh_r  <= 3'd0;
      tx_cnt_r <= 2'd0;
      miso_r   <= 1'b0;
    end else if ((state_r == S_COMMIT) && !sreg_r[5] && !spi.spi_ss_n) begin
      miso_r   <= rd_s[2];
      tx_sh_r  <= {rd_s[1:0], 1'b0};
      tx_cnt_r <= 2'd2;
    end else if ((tx_cnt_r != 2'd0) && !spi.spi_ss_n) begin
      miso_r   <= tx_sh_r[2];
      tx_sh_r  <= {tx_sh_r[1:0], 1'b0};
      tx_cnt_r <= tx_cnt_r - 2'd1;
    end else begin
      miso_r   <= 1'b0;
      tx_sh_r  <= tx_sh_r;
      tx_cnt_r <= 2'd0;
    end
  end

  assign spi.spi_miso = miso_r;
`else
  assign spi.spi_miso = 1'b0;
`endif

endmodule
